// File: rtl/addsub_share_ctrl_pkg.sv
// Shared encodings for the time-shared add/subtract controller.
package addsub_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Same op encoding as the existing add/sub unit.
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // Round-robin successor of index w among n requesters.
    function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/addsub_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module addsub_share_ctrl_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        gnt  = '0;
        id   = '0;
        any  = 1'b0;
        idx  = 0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                id        = cand;
            end
        end
    end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Shares one adder/subtractor among N_REQ requesters; holds each tagged result until acked.
module addsub_share_ctrl
    import addsub_share_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [N_REQ-1:0]       iREQ,
    input  logic [N_REQ*WIDTH-1:0] iA,
    input  logic [N_REQ*WIDTH-1:0] iB,
    input  logic [N_REQ-1:0]       iSEL,
    input  logic                   iACK,
    output logic [N_REQ-1:0]       oGNT,
    output logic                   oVALID,
    output logic [WIDTH-1:0]       oRES,
    output logic                   oCOUT,
    output logic                   oZERO,
    output logic [ID_W-1:0]        oID,
    output logic                   oBUSY
);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic [ID_W-1:0]  id_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_id;
    logic             arb_any;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_sel;
    logic [ID_W-1:0]  ptr_next;
    logic [WIDTH:0]   alu;

    addsub_share_ctrl_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req (iREQ),
        .ptr (ptr),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    always_comb begin
        win_a    = iA[int'(arb_id)*WIDTH +: WIDTH];
        win_b    = iB[int'(arb_id)*WIDTH +: WIDTH];
        win_sel  = iSEL[arb_id];
        ptr_next = ID_W'(rr_next(int'(arb_id), N_REQ));
    end

    // The extra MSB is the carry on add and the borrow (A<B) on subtract.
    always_comb begin
        if (sel_q == OP_ADD) begin
            alu = {1'b0, a_q} + {1'b0, b_q};
        end else begin
            alu = {1'b0, a_q} - {1'b0, b_q};
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= OP_SUB;
            id_q   <= '0;
            oGNT   <= '0;
            oVALID <= 1'b0;
            oRES   <= '0;
            oCOUT  <= 1'b0;
            oZERO  <= 1'b0;
            oID    <= '0;
        end else begin
            oGNT <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        a_q   <= win_a;
                        b_q   <= win_b;
                        sel_q <= win_sel;
                        id_q  <= arb_id;
                        oGNT  <= arb_gnt;
                        ptr   <= ptr_next;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    oRES   <= alu[WIDTH-1:0];
                    oCOUT  <= alu[WIDTH];
                    oZERO  <= (alu[WIDTH-1:0] == '0);
                    oID    <= id_q;
                    oVALID <= 1'b1;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (iACK) begin
                        oVALID <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oBUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl with a result scoreboard.
module tb_addsub_share_ctrl;
    import addsub_share_ctrl_pkg::*;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int ID_W  = 2;
    localparam int EW    = ID_W + WIDTH + 2;

    logic                   iCLK;
    logic                   iRST;
    logic [N_REQ-1:0]       iREQ;
    logic [N_REQ*WIDTH-1:0] iA;
    logic [N_REQ*WIDTH-1:0] iB;
    logic [N_REQ-1:0]       iSEL;
    logic                   iACK;
    logic [N_REQ-1:0]       oGNT;
    logic                   oVALID;
    logic [WIDTH-1:0]       oRES;
    logic                   oCOUT;
    logic                   oZERO;
    logic [ID_W-1:0]        oID;
    logic                   oBUSY;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] sb[$];

    addsub_share_ctrl #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iREQ   (iREQ),
        .iA     (iA),
        .iB     (iB),
        .iSEL   (iSEL),
        .iACK   (iACK),
        .oGNT   (oGNT),
        .oVALID (oVALID),
        .oRES   (oRES),
        .oCOUT  (oCOUT),
        .oZERO  (oZERO),
        .oID    (oID),
        .oBUSY  (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] model(input int k, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic sel);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c;
        if (sel == OP_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[WIDTH-1:0];
            c = s[WIDTH];
        end else begin
            r = a - b;
            c = (a < b);
        end
        return {ID_W'(k), r, c, (r == '0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sel);
        iA[k*WIDTH +: WIDTH] = a;
        iB[k*WIDTH +: WIDTH] = b;
        iSEL[k]              = sel;
    endtask

    task automatic check_result(input string tag);
        logic [EW-1:0] e;
        check({tag, "_pending"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, {oID, oRES, oCOUT, oZERO}, e);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, oBUSY, 0);
        check({tag, "_gnt"}, oGNT, 0);
        check({tag, "_valid"}, oVALID, 0);
    endtask

    // One full transaction; hold = extra cycles with iACK low, keep = requester stays high.
    task automatic do_op(input logic [N_REQ-1:0] reqv, input int k, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sel, input int hold,
                         input bit keep, input string tag);
        logic [N_REQ-1:0] g;
        logic [EW-1:0]    seen;
        g    = '0;
        g[k] = 1'b1;
        set_ops(k, a, b, sel);
        sb.push_back(model(k, a, b, sel));
        iREQ = reqv;
        step();
        check({tag, "_gnt"}, oGNT, g);
        check({tag, "_busy"}, oBUSY, 1);
        check({tag, "_early_valid"}, oVALID, 0);
        if (!keep) iREQ = '0;
        step();
        check({tag, "_valid"}, oVALID, 1);
        check({tag, "_gnt_pulse"}, oGNT, 0);
        seen = {oID, oRES, oCOUT, oZERO};
        check_result(tag);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, oVALID, 1);
            check({tag, "_hold_res"}, {oID, oRES, oCOUT, oZERO}, seen);
            check({tag, "_hold_gnt"}, oGNT, 0);
        end
        iACK = 1'b1;
        step();
        iACK = 1'b0;
        check({tag, "_ack_valid"}, oVALID, 0);
        check({tag, "_ack_busy"}, oBUSY, 0);
    endtask

    initial begin
        int grants;
        int last;
        iRST = 1'b1;
        iREQ = '0;
        iA   = '0;
        iB   = '0;
        iSEL = '0;
        iACK = 1'b0;
        step();
        step();
        check_idle("reset");
        check("reset_res", {oID, oRES, oCOUT, oZERO}, 0);
        iRST = 1'b0;
        step();
        check_idle("post_reset");

        do_op(4'b0001, 0, 4'h9, 4'h8, OP_ADD, 3, 1'b0, "add_9_8");
        do_op(4'b0100, 2, 4'h3, 4'h5, OP_SUB, 0, 1'b0, "sub_borrow");
        do_op(4'b0100, 2, 4'h7, 4'h7, OP_SUB, 0, 1'b0, "sub_zero");

        iACK = 1'b1;
        step();
        step();
        check_idle("ack_in_idle");
        iACK = 1'b0;

        // Round robin from pointer 0 with every requester asking and ack tied high.
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            set_ops(k, WIDTH'(k + 3), WIDTH'(2 * k + 1), k[0]);
            sb.push_back(model(k, WIDTH'(k + 3), WIDTH'(2 * k + 1), k[0]));
        end
        iREQ   = 4'b1111;
        iACK   = 1'b1;
        grants = 0;
        last   = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (oVALID) check_result("rr_res");
            if (oGNT != '0) begin
                check("rr_order", oGNT, 1 << grants);
                if (grants > 0) check("rr_gap", c - last, 3);
                last   = c;
                iREQ   = iREQ & ~oGNT;
                grants = grants + 1;
            end
        end
        check("rr_grants", grants, 4);
        iACK = 1'b0;
        check_idle("rr_done");

        // Backpressure with the requester still asserted; it is regranted once IDLE.
        do_op(4'b0010, 1, 4'hC, 4'h5, OP_ADD, 10, 1'b1, "backpressure");
        sb.push_back(model(1, 4'hC, 4'h5, OP_ADD));
        step();
        check("bp_regrant", oGNT, 4'b0010);
        iREQ = '0;
        step();
        check("bp_regrant_valid", oVALID, 1);
        check_result("bp_regrant_res");
        iACK = 1'b1;
        step();
        iACK = 1'b0;
        check_idle("bp_done");

        // Pointer sits at 2 here; reset must put requester 0 back on top.
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        do_op(4'b0101, 0, 4'h2, 4'h9, OP_SUB, 0, 1'b0, "ptr_reset");

        // Reset during EXEC discards the transaction.
        set_ops(3, 4'hA, 4'h4, OP_ADD);
        iREQ = 4'b1000;
        step();
        check("midop_gnt", oGNT, 4'b1000);
        iRST = 1'b1;
        #1;
        check_idle("midop_rst");
        check("midop_rst_res", {oID, oRES, oCOUT, oZERO}, 0);
        step();
        step();
        check("midop_no_valid", oVALID, 0);
        iRST = 1'b0;
        sb.push_back(model(3, 4'hA, 4'h4, OP_ADD));
        step();
        check("midop_regrant", oGNT, 4'b1000);
        iREQ = '0;
        step();
        check("midop_valid", oVALID, 1);
        check_result("midop_res");
        iACK = 1'b1;
        step();
        iACK = 1'b0;

        // A request pulsed only during RESP is never granted.
        set_ops(0, 4'h1, 4'hF, OP_ADD);
        sb.push_back(model(0, 4'h1, 4'hF, OP_ADD));
        iREQ = 4'b0001;
        step();
        check("drop_gnt", oGNT, 4'b0001);
        iREQ = '0;
        step();
        check("drop_valid", oVALID, 1);
        check_result("drop_res");
        iREQ = 4'b0010;
        step();
        step();
        check("drop_resp_gnt", oGNT, 0);
        iREQ = '0;
        iACK = 1'b1;
        step();
        iACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("drop_never_gnt", oGNT, 0);
        end
        check_idle("drop_done");

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
